// File: rtl/commit_store_stage.sv
// Commit stage: registers RF writes and redirects, retires stores into an in-order store buffer.
// Define SB_FWD_EN to add the store-to-load forwarding lookup port.
module commit_store_stage #(
  parameter int unsigned SB_DEPTH        = 4,
  parameter int unsigned SB_STALL_MARGIN = 2
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      commit_valid_i,
  input  logic [31:0]               commit_pc_i,
  input  logic [31:0]               commit_instr_i,
  input  logic [4:0]                commit_rd_addr_i,
  input  logic [31:0]               commit_result_i,
  input  logic                      commit_write_enable_i,
  input  logic                      commit_store_to_mem_i,
  input  logic [31:0]               commit_new_pc_i,
  input  logic                      commit_branch_taken_i,
  output logic                      rf_we_o,
  output logic [4:0]                rf_waddr_o,
  output logic [31:0]               rf_wdata_o,
  output logic                      redirect_valid_o,
  output logic [31:0]               redirect_pc_o,
  output logic                      dmem_req_valid_o,
  output logic [31:0]               dmem_req_addr_o,
  output logic [31:0]               dmem_req_data_o,
  output logic [3:0]                dmem_req_be_o,
  input  logic                      dmem_req_ready_i,
  output logic [$clog2(SB_DEPTH):0] sb_count_o,
  output logic                      sb_empty_o,
  output logic                      sb_stall_o,
  output logic                      sb_overflow_o,
`ifdef SB_FWD_EN
  input  logic [31:0]               fwd_addr_i,
  output logic                      fwd_hit_o,
  output logic [31:0]               fwd_data_o,
  output logic [3:0]                fwd_be_o,
`endif
  output logic                      sb_misalign_o
);

  localparam int unsigned PW = $clog2(SB_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StReq  = 1'b1;

  logic          rf_we_q, redirect_valid_q, misalign_q, overflow_q;
  logic [4:0]    rf_waddr_q;
  logic [31:0]   rf_wdata_q, redirect_pc_q;
  logic [0:0]    state_q, state_d;
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d, free_cnt;

  logic [29:0]   sb_addr_q [SB_DEPTH];
  logic [31:0]   sb_data_q [SB_DEPTH];
  logic [3:0]    sb_be_q   [SB_DEPTH];

  logic [1:0]    st_off;
  logic [3:0]    st_be;
  logic [31:0]   st_data;
  logic          st_misalign;
  logic          enq_req, enq, deq, full;

  logic unused_commit_bits;
  assign unused_commit_bits = ^{commit_pc_i, commit_instr_i[31:15], commit_instr_i[11:0]};

  // Lane alignment of the committed store; data travels on the new_pc bus for stores.
  always_comb begin
    st_off      = commit_result_i[1:0];
    st_be       = 4'b0000;
    st_data     = 32'h0;
    st_misalign = 1'b0;
    case (commit_instr_i[14:12])
      3'b000: begin
        st_be   = 4'b0001 << st_off;
        st_data = {24'h0, commit_new_pc_i[7:0]} << {st_off, 3'b000};
      end
      3'b001: begin
        st_be       = 4'b0011 << st_off;
        st_data     = {16'h0, commit_new_pc_i[15:0]} << {st_off, 3'b000};
        st_misalign = st_off[0];
      end
      3'b010: begin
        st_be       = 4'b1111;
        st_data     = commit_new_pc_i;
        st_misalign = (st_off != 2'b00);
      end
      default: st_misalign = 1'b1;
    endcase
  end

  assign full    = (count_q == CW'(SB_DEPTH));
  assign deq     = (state_q == StReq) && dmem_req_ready_i;
  assign enq_req = commit_valid_i && commit_store_to_mem_i && !st_misalign;
  // A full buffer still accepts a store when the head leaves on the same edge.
  assign enq     = enq_req && (!full || deq);

  always_comb begin
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    state_d = (count_d != '0) ? StReq : StIdle;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rf_we_q          <= 1'b0;
      rf_waddr_q       <= 5'd0;
      rf_wdata_q       <= 32'h0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0;
      misalign_q       <= 1'b0;
      overflow_q       <= 1'b0;
      state_q          <= StIdle;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
    end else begin
      rf_we_q <= commit_valid_i && commit_write_enable_i && (commit_rd_addr_i != 5'd0);
      if (commit_valid_i && commit_write_enable_i && (commit_rd_addr_i != 5'd0)) begin
        rf_waddr_q <= commit_rd_addr_i;
        rf_wdata_q <= commit_result_i;
      end
      redirect_valid_q <= commit_valid_i && commit_branch_taken_i;
      if (commit_valid_i && commit_branch_taken_i) begin
        redirect_pc_q <= commit_new_pc_i;
      end
      misalign_q <= commit_valid_i && commit_store_to_mem_i && st_misalign;
      if (enq_req && full && !deq) begin
        overflow_q <= 1'b1;
      end
      if (enq) begin
        tail_q <= tail_q + PW'(1);
      end
      if (deq) begin
        head_q <= head_q + PW'(1);
      end
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // Payload storage needs no reset: every read is qualified by the count.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      sb_addr_q[tail_q] <= commit_result_i[31:2];
      sb_data_q[tail_q] <= st_data;
      sb_be_q[tail_q]   <= st_be;
    end
  end

  assign free_cnt = CW'(SB_DEPTH) - count_q;

  assign rf_we_o          = rf_we_q;
  assign rf_waddr_o       = rf_waddr_q;
  assign rf_wdata_o       = rf_wdata_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign dmem_req_valid_o = (state_q == StReq);
  assign dmem_req_addr_o  = dmem_req_valid_o ? {sb_addr_q[head_q], 2'b00} : 32'h0;
  assign dmem_req_data_o  = dmem_req_valid_o ? sb_data_q[head_q] : 32'h0;
  assign dmem_req_be_o    = dmem_req_valid_o ? sb_be_q[head_q] : 4'b0000;
  assign sb_count_o       = count_q;
  assign sb_empty_o       = (count_q == '0);
  assign sb_stall_o       = (free_cnt <= CW'(SB_STALL_MARGIN));
  assign sb_overflow_o    = overflow_q;
  assign sb_misalign_o    = misalign_q;

`ifdef SB_FWD_EN
  logic [PW-1:0] fwd_idx;
  logic          unused_fwd_bits;
  assign unused_fwd_bits = ^fwd_addr_i[1:0];

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = 32'h0;
    fwd_be_o   = 4'b0000;
    fwd_idx    = head_q;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (sb_addr_q[fwd_idx] == fwd_addr_i[31:2])) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = sb_data_q[fwd_idx];
        fwd_be_o   = sb_be_q[fwd_idx];
      end
    end
  end
`endif

endmodule
